// File: rtl/vga_scanout_pkg.sv
// Shared types, default 640x480@60 timing and small timing helpers for the
// vga_scanout block and its raster timing generator.
package vga_scanout_pkg;

   typedef struct packed {
      int unsigned visible;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_timing_t;

   // Per-clk control word carried through the framebuffer latency alignment
   typedef struct packed {
      logic hs;
      logic vs;
      logic vld;
   } align_t;

   localparam vga_timing_t VGA640_H = '{visible: 640, fp: 16, sync: 96, bp: 48};
   localparam vga_timing_t VGA480_V = '{visible: 480, fp: 10, sync: 2, bp: 33};

   function automatic int unsigned total(vga_timing_t t);
      return t.visible + t.fp + t.sync + t.bp;
   endfunction

   function automatic int unsigned sync_begin(vga_timing_t t);
      return t.visible + t.fp;
   endfunction

   function automatic int unsigned sync_end(vga_timing_t t);
      return t.visible + t.fp + t.sync - 1;
   endfunction

   // Bits needed to hold 0..n-1 (at least one)
   function automatic int unsigned cnt_w(int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine (master) and the
// framebuffer RAM (slave).
interface vga_scanout_if
   import vga_scanout_pkg::*;
#(
   parameter int unsigned FB_ADDR_W = 16,
   parameter int unsigned COLOR_W   = 1
) ();

   logic [FB_ADDR_W-1:0] fb_addr;
   logic                 fb_rd_en;
   logic [3*COLOR_W-1:0] fb_pixel;

   modport master (output fb_addr, output fb_rd_en, input fb_pixel);
   modport slave  (input fb_addr, input fb_rd_en, output fb_pixel);

endinterface

// File: rtl/vga_scanout_timing_gen.sv
// Raster timing generator: pixel-clock divider, h/v counters, visibility
// flags, raw (active-high) syncs and wrap strobes.
module vga_timing_gen
   import vga_scanout_pkg::*;
#(
   parameter int unsigned  PIX_DIV = 2,
   parameter vga_timing_t  H_T     = VGA640_H,
   parameter vga_timing_t  V_T     = VGA480_V,
   localparam int unsigned HCW     = cnt_w(total(H_T)),
   localparam int unsigned VCW     = cnt_w(total(V_T))
) (
   input  logic           clk,
   input  logic           rst_async,
   output logic           pix_ce,
   output logic [HCW-1:0] h_cnt,
   output logic [VCW-1:0] v_cnt,
   output logic           hvis,
   output logic           vvis,
   output logic           hsync_raw,
   output logic           vsync_raw,
   output logic           h_wrap,
   output logic           v_wrap
);

   logic h_last;
   logic v_last;

   generate
      if (PIX_DIV == 1) begin : g_nodiv
         assign pix_ce = 1'b1;
      end else begin : g_div
         localparam int unsigned DW = cnt_w(PIX_DIV);
         logic [DW-1:0] div_cnt;

         always_ff @(posedge clk or posedge rst_async) begin
            if (rst_async)                          div_cnt <= '0;
            else if (div_cnt == DW'(PIX_DIV - 1))   div_cnt <= '0;
            else                                    div_cnt <= div_cnt + 1'b1;
         end

         assign pix_ce = (div_cnt == DW'(PIX_DIV - 1));
      end
   endgenerate

   assign h_last = (h_cnt == HCW'(total(H_T) - 1));
   assign v_last = (v_cnt == VCW'(total(V_T) - 1));
   assign h_wrap = pix_ce & h_last;
   assign v_wrap = h_wrap & v_last;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign hvis      = (h_cnt < HCW'(H_T.visible));
   assign vvis      = (v_cnt < VCW'(V_T.visible));
   assign hsync_raw = (h_cnt >= HCW'(sync_begin(H_T))) && (h_cnt <= HCW'(sync_end(H_T)));
   assign vsync_raw = (v_cnt >= VCW'(sync_begin(V_T))) && (v_cnt <= VCW'(sync_end(V_T)));

endmodule

// File: rtl/vga_scanout.sv
// Parametrised VGA raster generator with up-scaled framebuffer scanout.
// Optional sticky vblank interrupt enabled by defining VGA_SCANOUT_VBLANK_IRQ_EN.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int unsigned PIX_DIV    = 2,
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          HSYNC_POL  = 1'b0,
   parameter bit          VSYNC_POL  = 1'b0,
   parameter int unsigned X_SCALE    = 3,
   parameter int unsigned Y_SCALE    = 3,
   parameter int unsigned FB_WIDTH   = 214,
   parameter int unsigned FB_HEIGHT  = 160,
   parameter int unsigned FB_ADDR_W  = 16,
   parameter int unsigned COLOR_W    = 1,
   parameter int unsigned FB_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_async,
   input  logic               en,
   vga_scanout_if.master      fb,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               vga_hsync,
   output logic               vga_vsync,
   output logic               frame_start,
   output logic               vblank_irq,
   input  logic               irq_ack
);

   localparam vga_timing_t H_T = '{visible: H_VISIBLE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam vga_timing_t V_T = '{visible: V_VISIBLE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int unsigned HCW = cnt_w(total(H_T));
   localparam int unsigned VCW = cnt_w(total(V_T));
   localparam int unsigned SXW = cnt_w(X_SCALE);
   localparam int unsigned FXW = cnt_w(H_VISIBLE);
   localparam int unsigned SYW = cnt_w(Y_SCALE);
   localparam int unsigned FYW = cnt_w(total(V_T) + 1);

   logic                 pix_ce, hvis, vvis, hsync_raw, vsync_raw, h_wrap, v_wrap;
   logic [HCW-1:0]       h_cnt;
   logic [VCW-1:0]       v_cnt;
   logic [SXW-1:0]       sub_x;
   logic [FXW-1:0]       fb_x;
   logic [SYW-1:0]       sub_y;
   logic [FYW-1:0]       fb_y;
   logic [FB_ADDR_W-1:0] line_base;
   logic                 fb_area;
   align_t               stage_p0;
   align_t               align_d;

   vga_timing_gen #(
      .PIX_DIV (PIX_DIV),
      .H_T     (H_T),
      .V_T     (V_T)
   ) u_timing (
      .clk       (clk),
      .rst_async (rst_async),
      .pix_ce    (pix_ce),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .hvis      (hvis),
      .vvis      (vvis),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .h_wrap    (h_wrap),
      .v_wrap    (v_wrap)
   );

   // Horizontal fb mapping: clears on the last visible pixel so x=0 starts fresh
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         sub_x <= '0;
         fb_x  <= '0;
      end else if (pix_ce) begin
         if (!hvis || (h_cnt == HCW'(H_VISIBLE - 1))) begin
            sub_x <= '0;
            fb_x  <= '0;
         end else if (sub_x == SXW'(X_SCALE - 1)) begin
            sub_x <= '0;
            fb_x  <= fb_x + 1'b1;
         end else begin
            sub_x <= sub_x + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         sub_y     <= '0;
         fb_y      <= '0;
         line_base <= '0;
      end else if (h_wrap) begin
         if (v_wrap) begin
            sub_y     <= '0;
            fb_y      <= '0;
            line_base <= '0;
         end else if (sub_y == SYW'(Y_SCALE - 1)) begin
            sub_y     <= '0;
            fb_y      <= fb_y + 1'b1;
            line_base <= line_base + FB_ADDR_W'(FB_WIDTH);
         end else begin
            sub_y <= sub_y + 1'b1;
         end
      end
   end

   assign fb_area     = hvis && vvis && (32'(fb_x) < FB_WIDTH) && (32'(fb_y) < FB_HEIGHT);
   assign fb.fb_addr  = line_base + FB_ADDR_W'(fb_x);
   // Counters sit at (0,0) during reset, so the strobe is held off by reset itself
   assign fb.fb_rd_en = fb_area && !rst_async;
   assign stage_p0    = '{hs: hsync_raw, vs: vsync_raw, vld: fb_area};

   // Stage p1..pN: delay control to meet the framebuffer read data
   generate
      if (FB_LATENCY == 0) begin : g_nolat
         assign align_d = stage_p0;
      end else begin : g_lat
         align_t dly_p [FB_LATENCY];

         always_ff @(posedge clk or posedge rst_async) begin
            if (rst_async) begin
               for (int i = 0; i < FB_LATENCY; i++) dly_p[i] <= '0;
            end else begin
               dly_p[0] <= stage_p0;
               for (int i = 1; i < FB_LATENCY; i++) dly_p[i] <= dly_p[i-1];
            end
         end

         assign align_d = dly_p[FB_LATENCY-1];
      end
   endgenerate

   // Output register stage: colours, syncs and blanking update together
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_hsync             <= ~HSYNC_POL;
         vga_vsync             <= ~VSYNC_POL;
         frame_start           <= 1'b0;
      end else begin
         {vga_r, vga_g, vga_b} <= (en && align_d.vld) ? fb.fb_pixel : '0;
         vga_hsync             <= (en && align_d.hs) ? HSYNC_POL : ~HSYNC_POL;
         vga_vsync             <= (en && align_d.vs) ? VSYNC_POL : ~VSYNC_POL;
         frame_start           <= v_wrap;
      end
   end

`ifdef VGA_SCANOUT_VBLANK_IRQ_EN
   logic irq_set;
   assign irq_set = h_wrap && (v_cnt == VCW'(V_VISIBLE - 1));

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async)     vblank_irq <= 1'b0;
      else if (irq_set)  vblank_irq <= 1'b1;
      else if (irq_ack)  vblank_irq <= 1'b0;
   end
`else
   logic unused_irq;
   assign unused_irq = irq_ack ^ (^v_cnt);
   assign vblank_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised scoreboard bench for vga_scanout on a small raster with a
// partial last fb column/row, latency 2 and mixed sync polarities.
module tb_vga_scanout;

   localparam int PD = 2;
   localparam int HV = 10, HF = 2, HS = 3, HB = 2;
   localparam int VV = 7, VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT * PD;
   localparam int XS = 3, YS = 2, FBW = 3, FBH = 3;
   localparam int AW = 8, CW = 2, PW = 3 * CW, LAT = 2;
   localparam bit HPOL = 1'b0, VPOL = 1'b1;

   logic          clk = 1'b0;
   logic          rst_async, en, irq_ack;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   logic          vga_hsync, vga_vsync, frame_start, vblank_irq;

   vga_scanout_if #(.FB_ADDR_W(AW), .COLOR_W(CW)) fb ();

   vga_scanout #(
      .PIX_DIV(PD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .X_SCALE(XS), .Y_SCALE(YS),
      .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .FB_ADDR_W(AW), .COLOR_W(CW), .FB_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_async(rst_async), .en(en), .fb(fb),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .frame_start(frame_start), .vblank_irq(vblank_irq), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [PW-1:0] rgb;
      bit          hs, vs, fs, irq;
   } exp_t;

   typedef struct {
      bit rd;
      int addr;
   } rd_t;

   exp_t          sb[$];
   rd_t           hist[$];
   logic [PW-1:0] mem [256];
   int            total = 0, bad = 0, cyc = 0;
   bit            active = 0, irq_m = 0;

   // Reference raster: pure function of clocks since reset release
   function automatic int px(int t); return (t / PD) % HT; endfunction
   function automatic int py(int t); return (t / (PD * HT)) % VT; endfunction

   function automatic bit area(int t);
      int x, y;
      x = px(t); y = py(t);
      return (x < HV) && (y < VV) && (x / XS < FBW) && (y / YS < FBH);
   endfunction

   function automatic int addr(int t);
      int x, y;
      x = px(t); y = py(t);
      return ((y / YS) * FBW + ((x < HV) ? x / XS : 0)) % (1 << AW);
   endfunction

   function automatic bit hs_raw(int t);
      return (px(t) >= HV + HF) && (px(t) < HV + HF + HS);
   endfunction

   function automatic bit vs_raw(int t);
      return (py(t) >= VV + VF) && (py(t) < VV + VF + VS);
   endfunction

   function automatic bit irq_rise(int t);
      return (t % PD == 0) && (px(t) == 0) && (py(t) == VV);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'(0));
      check({tag, "_hsync"}, 32'(vga_hsync), 32'(!HPOL));
      check({tag, "_vsync"}, 32'(vga_vsync), 32'(!VPOL));
      check({tag, "_rd_en"}, 32'(fb.fb_rd_en), 32'(0));
      check({tag, "_addr"},  32'(fb.fb_addr), 32'(0));
      check({tag, "_fs"},    32'(frame_start), 32'(0));
      check({tag, "_irq"},   32'(vblank_irq), 32'(0));
   endtask

   task automatic release_rst();
      rst_async = 1'b0;
      cyc       = 0;
      irq_m     = 0;
      sb.delete();
      active    = 1;
   endtask

   task automatic run(input int n, input int mode);
      int ln;
      repeat (n) begin
         @(posedge clk);
         #1;
         ln = cyc / (PD * HT);
         case (mode)
            0: begin
               en = 1'b1;
               irq_ack = 1'b0;
            end
            1: begin
               if ($urandom_range(0, 39) == 0) en = !en;
               irq_ack = ($urandom_range(0, 29) == 0) || irq_rise(cyc + 1);
            end
            default: begin
               en = !(((ln % 3 == 1) && px(cyc) >= 5) || ((ln % 3 == 2) && px(cyc) < 4));
               irq_ack = 1'b0;
            end
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (active) cyc++;
   end

   // Framebuffer RAM with LAT-cycle read latency; junk when no read was issued
   initial begin
      fb.fb_pixel = '0;
      forever begin
         rd_t r;
         @(negedge clk);
         if (!active) begin
            hist.delete();
            fb.fb_pixel = PW'($urandom);
         end else begin
            r.rd   = fb.fb_rd_en;
            r.addr = int'(fb.fb_addr);
            hist.push_back(r);
            if (hist.size() > LAT + 1) void'(hist.pop_front());
            if (hist.size() == LAT + 1 && hist[0].rd) fb.fb_pixel = mem[hist[0].addr];
            else                                       fb.fb_pixel = PW'($urandom);
         end
      end
   end

   // Model: checks the read port now and queues the pin state due next clk
   initial forever begin
      @(negedge clk);
      if (active) begin
         exp_t e;
         int   t;
         check("fb_rd_en", 32'(fb.fb_rd_en), 32'(area(cyc)));
         check("fb_addr",  32'(fb.fb_addr),  32'(addr(cyc)));
         t     = cyc - LAT;
         e.cyc = cyc + 1;
         e.rgb = (en && t >= 0 && area(t)) ? mem[addr(t)] : '0;
         e.hs  = (en && t >= 0 && hs_raw(t)) ? HPOL : !HPOL;
         e.vs  = (en && t >= 0 && vs_raw(t)) ? VPOL : !VPOL;
         e.fs  = ((cyc + 1) % FRAME == 0);
`ifdef VGA_SCANOUT_VBLANK_IRQ_EN
         irq_m = irq_rise(cyc + 1) || (irq_m && !irq_ack);
`else
         irq_m = 0;
`endif
         e.irq = irq_m;
         sb.push_back(e);
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      while (active && sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check("rgb",         32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
         check("hsync",       32'(vga_hsync),   32'(e.hs));
         check("vsync",       32'(vga_vsync),   32'(e.vs));
         check("frame_start", 32'(frame_start), 32'(e.fs));
         check("vblank_irq",  32'(vblank_irq),  32'(e.irq));
      end
   end

   initial begin
      rst_async = 1'b1;
      en        = 1'b1;
      irq_ack   = 1'b0;
      foreach (mem[i]) mem[i] = PW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      release_rst();

      run(2 * FRAME, 0);
      run(3 * FRAME, 1);
      run($urandom_range(FRAME / 3, 2 * FRAME / 3), 1);

      rst_async = 1'b1;
      active    = 0;
      en        = 1'b1;
      irq_ack   = 1'b0;
      sb.delete();
      #1;
      check_reset("mid");
      repeat (3) @(posedge clk);
      #1;
      release_rst();

      run(FRAME + 8, 0);
      run(2 * FRAME, 2);
      run(FRAME, 1);
      check("sb_depth", 32'(sb.size()), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
